// File: rtl/cpu_wb_trace_pkg.sv
// Shared types, default widths and helpers for the writeback trace unit.
// CPU_WB_TRACE_STAMP_EN adds a cycle stamp field to the trace entry.
package cpu_wb_trace_pkg;

   localparam int unsigned DEF_DATA_W  = 16;
   localparam int unsigned DEF_RADDR_W = 2;
   localparam int unsigned DEF_STAMP_W = 16;

   typedef struct packed {
      logic [DEF_RADDR_W-1:0] wreg;
      logic [DEF_DATA_W-1:0]  data;
      logic [DEF_DATA_W-1:0]  pc;
`ifdef CPU_WB_TRACE_STAMP_EN
      logic [DEF_STAMP_W-1:0] stamp;
`endif
   } trc_entry_t;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/cpu_wb_trace_if.sv
// Valid/ready trace drain bus between the capture unit and its consumer.
interface cpu_wb_trace_if #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned RADDR_W = 2,
   parameter int unsigned STAMP_W = 16
);
   logic               trc_valid;
   logic               trc_ready;
   logic [RADDR_W-1:0] trc_reg;
   logic [DATA_W-1:0]  trc_data;
   logic [DATA_W-1:0]  trc_pc;
   logic [STAMP_W-1:0] trc_stamp;

   modport master (
      output trc_valid, trc_reg, trc_data, trc_pc, trc_stamp,
      input  trc_ready
   );

   modport slave (
      input  trc_valid, trc_reg, trc_data, trc_pc, trc_stamp,
      output trc_ready
   );
endinterface

// File: rtl/cpu_wb_trace_fifo.sv
// First-word-fall-through synchronous FIFO; head entry read straight from storage.
// A push while full is accepted only when a pop frees the slot in the same cycle.
module sync_fifo_fwft
   import cpu_wb_trace_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int unsigned IDX_W = clog2(DEPTH);
   localparam int unsigned PTR_W = IDX_W + 1;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                    (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem_q[rd_ptr_q[IDX_W-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      if (do_push) begin
         mem_d[wr_ptr_q[IDX_W-1:0]] = din;
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
   end

   // Storage is cleared on reset so the head presents zeros while empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end
endmodule

// File: rtl/cpu_wb_trace.sv
// Writeback trace capture: queues register-file writes and counts events lost to a full FIFO.
// Define CPU_WB_TRACE_STAMP_EN to attach a free-running cycle stamp to each entry.
module cpu_wb_trace
   import cpu_wb_trace_pkg::*;
#(
   parameter int unsigned DATA_W  = DEF_DATA_W,
   parameter int unsigned RADDR_W = DEF_RADDR_W,
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned DROP_W  = 8,
   parameter int unsigned STAMP_W = DEF_STAMP_W
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                RegWrite,
   input  logic [RADDR_W-1:0]  WriteReg,
   input  logic [DATA_W-1:0]   WriteData,
   input  logic [DATA_W-1:0]   PC,
   cpu_wb_trace_if.master      trc,
   output logic [DROP_W-1:0]   drop_cnt,
   output logic                overflow
);
`ifdef CPU_WB_TRACE_STAMP_EN
   localparam int unsigned ENTRY_W = RADDR_W + 2 * DATA_W + STAMP_W;
`else
   localparam int unsigned ENTRY_W = RADDR_W + 2 * DATA_W;
`endif

   logic [ENTRY_W-1:0] fifo_din;
   logic [ENTRY_W-1:0] fifo_dout;
   logic               fifo_full;
   logic               fifo_empty;
   logic               pop_c;
   logic               drop_c;
   logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d;
   logic               overflow_q, overflow_d;

`ifdef CPU_WB_TRACE_STAMP_EN
   logic [STAMP_W-1:0] stamp_q, stamp_d;

   always_comb begin
      stamp_d = stamp_q + STAMP_W'(1);
   end

   always_ff @(posedge Clock) begin
      if (Reset) stamp_q <= '0;
      else       stamp_q <= stamp_d;
   end

   assign fifo_din      = {WriteReg, WriteData, PC, stamp_q};
   assign trc.trc_stamp = fifo_dout[STAMP_W-1:0];
`else
   assign fifo_din      = {WriteReg, WriteData, PC};
   assign trc.trc_stamp = '0;
`endif

   // A pop in the same cycle frees the slot, so a write at full is then accepted.
   assign pop_c  = !fifo_empty && trc.trc_ready;
   assign drop_c = RegWrite && fifo_full && !pop_c;

   sync_fifo_fwft #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (Clock),
      .rst   (Reset),
      .push  (RegWrite),
      .pop   (pop_c),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign trc.trc_valid = !fifo_empty;
   assign trc.trc_reg   = fifo_dout[ENTRY_W-1 -: RADDR_W];
   assign trc.trc_data  = fifo_dout[ENTRY_W-RADDR_W-1 -: DATA_W];
   assign trc.trc_pc    = fifo_dout[ENTRY_W-RADDR_W-DATA_W-1 -: DATA_W];

   // Saturating drop counter and sticky overflow flag.
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      overflow_d = overflow_q;
      if (drop_c) begin
         overflow_d = 1'b1;
         if (drop_cnt_q != {DROP_W{1'b1}}) drop_cnt_d = drop_cnt_q + DROP_W'(1);
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         drop_cnt_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
         overflow_q <= overflow_d;
      end
   end

   assign drop_cnt = drop_cnt_q;
   assign overflow = overflow_q;
endmodule

// File: tb/tb_cpu_wb_trace.sv
// Scoreboard bench for cpu_wb_trace: driver queues expected entries, monitor pops and compares.
// A second instance with a 2-bit drop counter exercises saturation.
module tb_cpu_wb_trace;
   import cpu_wb_trace_pkg::*;

   logic        clk = 1'b0;
   logic        Reset = 1'b1;
   logic        RegWrite = 1'b0;
   logic [1:0]  WriteReg = '0;
   logic [15:0] WriteData = '0;
   logic [15:0] PC = '0;
   logic        rdy = 1'b0;
   logic [7:0]  drop_cnt;
   logic        overflow;
   logic [1:0]  drop_cnt2;
   logic        overflow2;

   int          checks = 0;
   int          failures = 0;
   bit          started = 1'b0;
   trc_entry_t  exp_q[$];
   int          exp_drop = 0;
   int          exp_drop2 = 0;
   bit          exp_ovf = 1'b0;

`ifdef CPU_WB_TRACE_STAMP_EN
   logic [15:0] tb_stamp = '0;
   always @(posedge clk) tb_stamp <= Reset ? 16'd0 : tb_stamp + 16'd1;
`endif

   always #5 clk = ~clk;

   cpu_wb_trace_if #(.DATA_W(16), .RADDR_W(2), .STAMP_W(16)) if1 ();
   cpu_wb_trace_if #(.DATA_W(16), .RADDR_W(2), .STAMP_W(16)) if2 ();
   assign if1.trc_ready = rdy;
   assign if2.trc_ready = rdy;

   cpu_wb_trace #(.DATA_W(16), .RADDR_W(2), .DEPTH(8), .DROP_W(8), .STAMP_W(16)) dut (
      .Clock(clk), .Reset(Reset), .RegWrite(RegWrite), .WriteReg(WriteReg),
      .WriteData(WriteData), .PC(PC), .trc(if1), .drop_cnt(drop_cnt), .overflow(overflow)
   );

   cpu_wb_trace #(.DATA_W(16), .RADDR_W(2), .DEPTH(8), .DROP_W(2), .STAMP_W(16)) dut_sat (
      .Clock(clk), .Reset(Reset), .RegWrite(RegWrite), .WriteReg(WriteReg),
      .WriteData(WriteData), .PC(PC), .trc(if2), .drop_cnt(drop_cnt2), .overflow(overflow2)
   );

   task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compare head against scoreboard every cycle, pop on handshake.
   always @(negedge clk) begin
      if (started && !Reset) begin
         chk("valid", if1.trc_valid == (exp_q.size() != 0), 64'(if1.trc_valid), 64'(exp_q.size() != 0));
         if (if1.trc_valid && exp_q.size() != 0) begin
            chk("head", {if1.trc_reg, if1.trc_data, if1.trc_pc} == {exp_q[0].wreg, exp_q[0].data, exp_q[0].pc},
                64'({if1.trc_reg, if1.trc_data, if1.trc_pc}), 64'({exp_q[0].wreg, exp_q[0].data, exp_q[0].pc}));
`ifdef CPU_WB_TRACE_STAMP_EN
            chk("stamp", if1.trc_stamp == exp_q[0].stamp, 64'(if1.trc_stamp), 64'(exp_q[0].stamp));
`else
            chk("stamp_zero", if1.trc_stamp == 16'd0, 64'(if1.trc_stamp), 64'd0);
`endif
            if (rdy) void'(exp_q.pop_front());
         end
         chk("drop_cnt", drop_cnt == 8'(exp_drop), 64'(drop_cnt), 64'(exp_drop));
         chk("overflow", overflow == exp_ovf, 64'(overflow), 64'(exp_ovf));
         chk("drop_cnt_sat", drop_cnt2 == 2'(exp_drop2), 64'(drop_cnt2), 64'(exp_drop2));
         chk("overflow_sat", overflow2 == exp_ovf, 64'(overflow2), 64'(exp_ovf));
      end
   end

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wr(input logic [1:0] r, input logic [15:0] d, input logic [15:0] p, input bit acc);
      trc_entry_t e;
      e.wreg = r; e.data = d; e.pc = p;
`ifdef CPU_WB_TRACE_STAMP_EN
      e.stamp = tb_stamp;
`endif
      RegWrite = 1'b1; WriteReg = r; WriteData = d; PC = p;
      @(posedge clk); #1;
      RegWrite = 1'b0;
      if (acc) exp_q.push_back(e);
      else begin
         if (exp_drop < 255) exp_drop++;
         if (exp_drop2 < 3) exp_drop2++;
         exp_ovf = 1'b1;
      end
   endtask

   task automatic do_reset(input int n, input bit with_wr);
      Reset = 1'b1; RegWrite = with_wr; WriteReg = 2'd3; WriteData = 16'hFFFF; PC = 16'hFFFE;
      repeat (n) @(posedge clk);
      #1;
      Reset = 1'b0; RegWrite = 1'b0;
      exp_q.delete();
      exp_drop = 0; exp_drop2 = 0; exp_ovf = 1'b0;
      started = 1'b1;
      // Outputs must read all zero straight after reset.
      @(negedge clk);
      chk("rst_outputs", {if1.trc_valid, if1.trc_reg, if1.trc_data, if1.trc_pc, if1.trc_stamp} == '0,
          64'({if1.trc_valid, if1.trc_reg, if1.trc_data, if1.trc_pc}), 64'd0);
      @(posedge clk); #1;
   endtask

   task automatic drain(input int n);
      rdy = 1'b1; idle(n); rdy = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      // Reset with RegWrite held high captures nothing.
      do_reset(2, 1'b1);
      idle(2);

      // Single capture held stable while not ready.
      wr(2'd2, 16'h00A5, 16'h0004, 1'b1);
      idle(5);
      drain(2);

      // Fill to full, one drop, then drain in order.
      for (int i = 1; i <= 8; i++) wr(2'(i), 16'(i), 16'(i * 2), 1'b1);
      wr(2'd1, 16'd9, 16'd18, 1'b0);
      drain(10);

      // Simultaneous push and pop at full is accepted; follow-up write proves still full.
      for (int i = 0; i < 8; i++) wr(2'(i), 16'h0010 + 16'(i), 16'h0100 + 16'(i), 1'b1);
      rdy = 1'b1;
      wr(2'd3, 16'h0055, 16'h0200, 1'b1);
      rdy = 1'b0;
      wr(2'd0, 16'h0066, 16'h0202, 1'b0);
      drain(10);

      // Saturation of the narrow counter.
      do_reset(1, 1'b0);
      for (int i = 0; i < 8; i++) wr(2'(i), 16'h0A00 + 16'(i), 16'h0300 + 16'(i), 1'b1);
      for (int i = 0; i < 6; i++) wr(2'd0, 16'h0B00 + 16'(i), 16'h0400 + 16'(i), 1'b0);
      idle(1);

      // Mid-run reset discards queued entries.
      do_reset(1, 1'b0);
      for (int i = 0; i < 4; i++) wr(2'(i), 16'h0C00 + 16'(i), 16'h0500 + 16'(i), 1'b1);
      do_reset(1, 1'b0);
      wr(2'd0, 16'h1234, 16'h0600, 1'b1);
      drain(4);
      idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
